// File: rtl/flex_down_counter.sv
// Loadable down-counter with optional auto-reload and a one-cycle expiry pulse.
// Two-state control (IDLE/RUN); count_out and expire_flag are registered.
module flex_down_counter #(
    parameter int unsigned NUM_CNT_BITS = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    input  logic                    load,
    input  logic [NUM_CNT_BITS-1:0] load_val,
    input  logic                    count_enable,
    input  logic                    auto_reload,
    output logic [NUM_CNT_BITS-1:0] count_out,
    output logic                    expire_flag,
    output logic                    busy
);

    localparam logic [NUM_CNT_BITS-1:0] CNT_ZERO = NUM_CNT_BITS'(0);
    localparam logic [NUM_CNT_BITS-1:0] CNT_ONE  = NUM_CNT_BITS'(1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [NUM_CNT_BITS-1:0] count_q, count_d;
    logic [NUM_CNT_BITS-1:0] period_q, period_d;
    logic                    expire_q, expire_d;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            count_q  <= CNT_ZERO;
            period_q <= CNT_ZERO;
            expire_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            period_q <= period_d;
            expire_q <= expire_d;
        end
    end

    // Next-state logic: clear beats load, load beats count_enable
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        period_d = period_q;
        expire_d = 1'b0;

        if (clear) begin
            state_d = IDLE;
            count_d = CNT_ZERO;
        end else if (load) begin
            period_d = load_val;
            if (load_val != CNT_ZERO) begin
                state_d = RUN;
                count_d = load_val;
            end else begin
                // A zero-length countdown expires immediately
                state_d  = IDLE;
                count_d  = CNT_ZERO;
                expire_d = 1'b1;
            end
        end else begin
            case (state_q)
                RUN: begin
                    if (count_enable) begin
                        if (count_q == CNT_ONE) begin
                            expire_d = 1'b1;
                            if (auto_reload) begin
                                count_d = period_q;
                            end else begin
                                state_d = IDLE;
                                count_d = CNT_ZERO;
                            end
                        end else begin
                            count_d = count_q - CNT_ONE;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    count_d = CNT_ZERO;
                end
            endcase
        end
    end

    // Output decode straight from registers
    always_comb begin
        count_out   = count_q;
        expire_flag = expire_q;
        busy        = (state_q == RUN);
    end

endmodule

// File: tb/tb_flex_down_counter.sv
// Directed bench for flex_down_counter: behavioural model compared every cycle,
// plus hand-computed literal expectations for the key scenarios.
module tb_flex_down_counter;

    localparam int unsigned N = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         clear;
    logic         load;
    logic [N-1:0] load_val;
    logic         count_enable;
    logic         auto_reload;
    logic [N-1:0] count_out;
    logic         expire_flag;
    logic         busy;

    int n_vec = 0;
    int n_err = 0;

    flex_down_counter #(.NUM_CNT_BITS(N)) dut (
        .clk          (clk),
        .rst          (rst),
        .clear        (clear),
        .load         (load),
        .load_val     (load_val),
        .count_enable (count_enable),
        .auto_reload  (auto_reload),
        .count_out    (count_out),
        .expire_flag  (expire_flag),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: remaining count, reload period, running flag, pulse
    int m_count  = 0;
    int m_period = 0;
    bit m_run    = 0;
    bit m_exp    = 0;
    bit m_valid  = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_count = 0; m_period = 0; m_run = 0; m_exp = 0; m_valid = 1;
        end else if (clear) begin
            m_count = 0; m_run = 0; m_exp = 0;
        end else if (load) begin
            m_period = int'(load_val);
            m_count  = int'(load_val);
            m_run    = (load_val != 0);
            m_exp    = (load_val == 0);
        end else if (m_run && count_enable) begin
            if (m_count == 1) begin
                m_exp   = 1;
                m_count = auto_reload ? m_period : 0;
                m_run   = auto_reload;
            end else begin
                m_count = m_count - 1;
                m_exp   = 0;
            end
        end else begin
            m_exp = 0;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("cmp_count", 32'(count_out), 32'(m_count));
            check("cmp_expire", 32'(expire_flag), 32'(m_exp));
            check("cmp_busy", 32'(busy), 32'(m_run));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic lit(input string name, input int c, input bit e, input bit b);
        check({name, "_count"}, 32'(count_out), 32'(c));
        check({name, "_expire"}, 32'(expire_flag), 32'(e));
        check({name, "_busy"}, 32'(busy), 32'(b));
    endtask

    task automatic do_load(input int v, input bit ar);
        load = 1; load_val = N'(v); auto_reload = ar;
        step();
        load = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_cnt[9];
        rst = 1; clear = 0; load = 0; load_val = '0; count_enable = 0; auto_reload = 0;
        step(); step();
        lit("reset", 0, 0, 0);
        rst = 0;

        // Countdown 5..0, no reload
        count_enable = 1;
        do_load(5, 0);
        lit("l5_load", 5, 0, 1);
        for (int i = 4; i >= 0; i--) begin
            step();
            lit("l5_run", i, (i == 0), (i != 0));
        end
        step();
        lit("l5_after", 0, 0, 0);

        // Auto-reload period 3
        do_load(3, 1);
        lit("ar3_load", 3, 0, 1);
        exp_cnt = '{2, 1, 3, 2, 1, 3, 2, 1, 3};
        for (int i = 0; i < 9; i++) begin
            step();
            lit("ar3_run", exp_cnt[i], (i % 3 == 2), 1);
        end

        // Enable toggling, period 4
        count_enable = 0;
        do_load(4, 0);
        for (int i = 0; i < 8; i++) begin
            count_enable = (i % 2 == 0);
            step();
            if (i == 6) lit("tog_expiry", 0, 1, 0);
            else if (i < 6) lit("tog_run", 3 - i / 2, 0, 1);
        end

        // All-ones load counts down without wrap
        count_enable = 1;
        do_load(15, 0);
        lit("max_load", 15, 0, 1);
        for (int i = 1; i <= 16; i++) begin
            step();
            if (i <= 15) lit("max_run", 15 - i, (i == 15), (i != 15));
            else lit("max_after", 0, 0, 0);
        end

        // Clear mid-count
        do_load(5, 0);
        repeat (3) step();
        lit("mid_pre", 2, 0, 1);
        clear = 1; load = 1; load_val = 4'd9;
        step();
        clear = 0; load = 0;
        lit("clear_mid", 0, 0, 0);

        // Reload mid-count
        do_load(5, 0);
        repeat (3) step();
        do_load(7, 0);
        lit("reload_mid", 7, 0, 1);

        // Reset mid-count, overriding load
        repeat (5) step();
        lit("mid_pre2", 2, 0, 1);
        rst = 1; load = 1; load_val = 4'd6;
        step();
        lit("rst_mid", 0, 0, 0);
        rst = 0; load = 0;

        // Zero load: immediate one-cycle pulse
        do_load(0, 1);
        lit("zero_load", 0, 1, 0);
        step();
        lit("zero_after", 0, 0, 0);

        // IDLE ignores enable and auto_reload
        count_enable = 1; auto_reload = 1;
        repeat (3) step();
        lit("idle_hold", 0, 0, 0);

        // RUN holds with enable low
        count_enable = 0;
        do_load(6, 0);
        repeat (3) step();
        lit("run_hold", 6, 0, 1);

        step();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
